// File: rtl/spi_seq_engine.sv
// Command sequencer in front of spi_bus: decodes 12-bit SPI commands and issues one
// byte transfer at a time over a start/done handshake. Read-back bytes land in a small FIFO.
module spi_seq_engine #(
  parameter int unsigned RD_FIFO_DEPTH = 4,
  parameter logic [7:0]  READ_FILL     = 8'h00
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [11:0] cmd_data_i,
  output logic        xfer_start_o,
  output logic [7:0]  xfer_tx_o,
  input  logic        xfer_done_i,
  input  logic [7:0]  xfer_rx_i,
  output logic        spi_ncs_o,
  output logic        rd_valid_o,
  output logic [7:0]  rd_data_o,
  input  logic        rd_ready_i,
  output logic        busy_o,
  output logic        err_o
);
  localparam int unsigned AW      = $clog2(RD_FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(RD_FIFO_DEPTH);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_CS_LO  = 4'd1;
  localparam logic [3:0] OP_CS_HI  = 4'd2;
  localparam logic [3:0] OP_WRITE  = 4'd3;
  localparam logic [3:0] OP_READ   = 4'd4;
  localparam logic [3:0] OP_XCHG   = 4'd5;
  localparam logic [3:0] OP_DELAY  = 4'd6;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_DELAY} state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [7:0]  arg_q, dly_q;
  logic        cmd_ready_q, xfer_start_q, ncs_q, busy_q, err_q;
  logic [7:0]  xfer_tx_q;

  logic [7:0]  mem_q [RD_FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count;
  logic        pop, push, slot_free, is_rd_op;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign rd_valid_o = (count != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign pop        = rd_valid_o & rd_ready_i;
  assign is_rd_op   = (op_q == OP_READ) || (op_q == OP_XCHG);
  assign push       = (state_q == S_WAIT) & xfer_done_i & is_rd_op;
  // Only one transfer is ever outstanding, so the slot checked here stays reserved until push.
  assign slot_free  = (count < DEPTH_W) | pop;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= xfer_rx_i;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      arg_q        <= 8'h00;
      dly_q        <= 8'h00;
      cmd_ready_q  <= 1'b0;
      xfer_start_q <= 1'b0;
      xfer_tx_q    <= 8'h00;
      ncs_q        <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      xfer_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          if (cmd_valid_i && cmd_ready_q) begin
            op_q        <= cmd_data_i[11:8];
            arg_q       <= cmd_data_i[7:0];
            state_q     <= S_DECODE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_DECODE: begin
          case (op_q)
            OP_WRITE: begin
              xfer_tx_q    <= arg_q;
              xfer_start_q <= 1'b1;
              state_q      <= S_ISSUE;
            end
            OP_READ, OP_XCHG: begin
              if (slot_free) begin
                xfer_tx_q    <= (op_q == OP_READ) ? READ_FILL : arg_q;
                xfer_start_q <= 1'b1;
                state_q      <= S_ISSUE;
              end
            end
            OP_DELAY: begin
              dly_q   <= arg_q;
              state_q <= S_DELAY;
            end
            default: begin
              if (op_q == OP_CS_LO) ncs_q <= 1'b0;
              if (op_q == OP_CS_HI) ncs_q <= 1'b1;
              if (op_q > OP_DELAY)  err_q <= 1'b1;
              state_q     <= S_IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          endcase
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (xfer_done_i) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        S_DELAY: begin
          if (dly_q == 8'h00) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            dly_q <= dly_q - 8'h01;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign xfer_start_o = xfer_start_q;
  assign xfer_tx_o    = xfer_tx_q;
  assign spi_ncs_o    = ncs_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_spi_seq_engine.sv
// Bench for spi_seq_engine: an SPI byte-engine responder plus a queue-based model of
// chip select, error flag, issued bytes and read FIFO contents.
module tb_spi_seq_engine;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic [11:0] cmd_data_i = '0;
  logic        rd_ready_i = 1'b0;
  logic        cmd_ready_o, xfer_start_o, spi_ncs_o, rd_valid_o, busy_o, err_o;
  logic [7:0]  xfer_tx_o, rd_data_o;
  logic        xfer_done_i;
  logic [7:0]  xfer_rx_i;

  logic        slave_en = 1'b1;
  int          slave_lat = 3;
  logic [7:0]  next_rx = 8'h00;
  logic        slave_done = 1'b0;
  logic [7:0]  slave_rx = 8'h00;
  logic        tb_done = 1'b0;
  logic [7:0]  tb_rx = 8'h00;

  int          start_cnt = 0;
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_fifo[$];
  logic        exp_ncs = 1'b1;
  logic        exp_err = 1'b0;
  int          checks = 0;
  int          failures = 0;

  assign xfer_done_i = slave_done | tb_done;
  assign xfer_rx_i   = tb_done ? tb_rx : slave_rx;

  spi_seq_engine #(.RD_FIFO_DEPTH(DEPTH), .READ_FILL(8'h00)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_data_i(cmd_data_i),
    .xfer_start_o(xfer_start_o), .xfer_tx_o(xfer_tx_o),
    .xfer_done_i(xfer_done_i), .xfer_rx_i(xfer_rx_i),
    .spi_ncs_o(spi_ncs_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .rd_ready_i(rd_ready_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (xfer_start_o === 1'b1) begin
      start_cnt <= start_cnt + 1;
      tx_log.push_back(xfer_tx_o);
    end
  end

  // Byte engine: answers each start with done after slave_lat cycles.
  initial forever begin
    @(negedge clk);
    if (slave_en && xfer_start_o === 1'b1) begin
      repeat (slave_lat) @(negedge clk);
      slave_done = 1'b1;
      slave_rx   = next_rx;
      @(negedge clk);
      slave_done = 1'b0;
    end
  end

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cmd_ready_o !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cmd_ready_o !== 1'b1) begin
      checks++; failures++;
      $display("FAIL ready_timeout: cmd_ready_o=%b after %0d cycles, required 1", cmd_ready_o, cyc);
    end
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [7:0] arg);
    int c;
    wait_ready(c);
    cmd_valid_i = 1'b1;
    cmd_data_i  = {op, arg};
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic pop_head();
    rd_ready_i = 1'b1;
    @(negedge clk);
    rd_ready_i = 1'b0;
    if (exp_fifo.size() != 0) void'(exp_fifo.pop_front());
  endtask

  task automatic test_reset();
    int c;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready_o, xfer_start_o, xfer_tx_o, spi_ncs_o, rd_valid_o, rd_data_o, busy_o, err_o}
        !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: rdy=%b st=%b tx=%h ncs=%b rv=%b rd=%h busy=%b err=%b",
               cmd_ready_o, xfer_start_o, xfer_tx_o, spi_ncs_o, rd_valid_o, rd_data_o, busy_o, err_o);
    end
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_ready_rise: got %b required 1", cmd_ready_o);
    end
    wait_ready(c);
  endtask

  task automatic test_cs_write();
    int c, s0;
    send_cmd(4'd1, 8'h00);
    checks++;
    if (spi_ncs_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
      failures++; $display("FAIL cs_decode_cycle: ncs=%b rdy=%b required 1 0", spi_ncs_o, cmd_ready_o);
    end
    @(negedge clk);
    checks++;
    if (spi_ncs_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL cs_low_timing: ncs=%b rdy=%b required 0 1", spi_ncs_o, cmd_ready_o);
    end
    s0 = start_cnt;
    slave_lat = 2;
    send_cmd(4'd3, 8'hA5);
    wait_ready(c);
    checks++;
    if (start_cnt - s0 != 1 || tx_log.size() != 1 || tx_log[0] !== 8'hA5) begin
      failures++; $display("FAIL write_pulse: starts=%0d logged=%0d required 1 pulse of a5", start_cnt - s0, tx_log.size());
    end
    tx_log.delete();
    checks++;
    if (rd_valid_o !== 1'b0 || spi_ncs_o !== 1'b0) begin
      failures++; $display("FAIL write_no_push: rv=%b ncs=%b required 0 0", rd_valid_o, spi_ncs_o);
    end
    send_cmd(4'd2, 8'h00);
    wait_ready(c);
    checks++;
    if (spi_ncs_o !== 1'b1) begin
      failures++; $display("FAIL cs_high: ncs=%b required 1", spi_ncs_o);
    end
  endtask

  task automatic test_xchg();
    int c;
    slave_lat = 5;
    next_rx = 8'hC3;
    send_cmd(4'd5, 8'h3C);
    wait_ready(c);
    checks++;
    if (c != 7) begin
      failures++; $display("FAIL xchg_latency: ready after %0d cycles required 7", c);
    end
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 8'hC3) begin
      failures++; $display("FAIL xchg_data: rv=%b rd=%h required 1 c3", rd_valid_o, rd_data_o);
    end
    checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h3C) begin
      failures++; $display("FAIL xchg_tx: logged=%0d required single 3c", tx_log.size());
    end
    tx_log.delete();
    exp_fifo.push_back(8'hC3);
    pop_head();
    checks++;
    if (rd_valid_o !== 1'b0) begin
      failures++; $display("FAIL xchg_pop: rv=%b required 0", rd_valid_o);
    end
  endtask

  task automatic test_fifo_stall();
    int c, s0;
    logic [7:0] r5;
    s0 = start_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      slave_lat = $urandom_range(6, 1);
      next_rx = 8'($urandom);
      send_cmd(4'd4, 8'($urandom));
      wait_ready(c);
      exp_fifo.push_back(next_rx);
    end
    r5 = 8'($urandom);
    next_rx = r5;
    send_cmd(4'd4, 8'h11);
    repeat (15) @(negedge clk);
    checks++;
    if (start_cnt - s0 != DEPTH || busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
      failures++; $display("FAIL stall: starts=%0d busy=%b rdy=%b required %0d 1 0", start_cnt - s0, busy_o, cmd_ready_o, DEPTH);
    end
    checks++;
    if (rd_data_o !== exp_fifo[0]) begin
      failures++; $display("FAIL stall_head: rd=%h required %h", rd_data_o, exp_fifo[0]);
    end
    pop_head();
    wait_ready(c);
    exp_fifo.push_back(r5);
    checks++;
    if (start_cnt - s0 != DEPTH + 1) begin
      failures++; $display("FAIL stall_release: starts=%0d required %0d", start_cnt - s0, DEPTH + 1);
    end
    checks++;
    if (tx_log.size() != DEPTH + 1 || tx_log[0] !== 8'h00 || tx_log[DEPTH] !== 8'h00) begin
      failures++; $display("FAIL read_fill: logged=%0d required %0d bytes of 00", tx_log.size(), DEPTH + 1);
    end
    tx_log.delete();
    while (exp_fifo.size() != 0) begin
      checks++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== exp_fifo[0]) begin
        failures++; $display("FAIL stall_order: rv=%b rd=%h required 1 %h", rd_valid_o, rd_data_o, exp_fifo[0]);
      end
      pop_head();
    end
    checks++;
    if (rd_valid_o !== 1'b0) begin
      failures++; $display("FAIL stall_drain: rv=%b required 0", rd_valid_o);
    end
  endtask

  task automatic test_delay();
    int n, k;
    int ks[3];
    ks[0] = 0; ks[1] = 10; ks[2] = $urandom_range(40, 1);
    for (int i = 0; i < 3; i++) begin
      k = ks[i];
      send_cmd(4'd6, 8'(k));
      n = 0;
      while (busy_o === 1'b1 && n < 600) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n != k + 2 || cmd_ready_o !== 1'b1) begin
        failures++; $display("FAIL delay_%0d: busy %0d cycles rdy=%b required %0d 1", k, n, cmd_ready_o, k + 2);
      end
    end
  endtask

  task automatic test_illegal();
    int c, s0;
    logic ncs0;
    s0 = start_cnt;
    ncs0 = spi_ncs_o;
    send_cmd(4'd9, 8'h5A);
    wait_ready(c);
    checks++;
    if (err_o !== 1'b1 || spi_ncs_o !== ncs0 || start_cnt != s0) begin
      failures++; $display("FAIL illegal_9: err=%b ncs=%b starts=%0d required 1 %b 0", err_o, spi_ncs_o, start_cnt - s0, ncs0);
    end
    exp_err = 1'b1;
    slave_lat = 1;
    send_cmd(4'd1, 8'h00);
    send_cmd(4'd3, 8'h42);
    send_cmd(4'd2, 8'h00);
    wait_ready(c);
    tx_log.delete();
    checks++;
    if (err_o !== 1'b1 || spi_ncs_o !== 1'b1) begin
      failures++; $display("FAIL err_sticky: err=%b ncs=%b required 1 1", err_o, spi_ncs_o);
    end
  endtask

  task automatic test_random();
    int c, s0, sel, nstart;
    logic [3:0] op;
    logic [7:0] arg;
    exp_ncs = spi_ncs_o;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(8, 0);
      op  = (sel >= 7) ? 4'($urandom_range(15, 7)) : 4'(sel);
      arg = (op == 4'd6) ? 8'($urandom_range(15, 0)) : 8'($urandom);
      if (exp_fifo.size() != 0 &&
          ($urandom_range(1, 0) == 1 || ((op == 4'd4 || op == 4'd5) && exp_fifo.size() == DEPTH))) begin
        checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== exp_fifo[0]) begin
          failures++; $display("FAIL rand_pop_%0d: rv=%b rd=%h required 1 %h", it, rv_str(), rd_data_o, exp_fifo[0]);
        end
        pop_head();
      end
      slave_lat = $urandom_range(6, 1);
      next_rx = 8'($urandom);
      s0 = start_cnt;
      send_cmd(op, arg);
      wait_ready(c);
      nstart = 0;
      case (op)
        4'd1: exp_ncs = 1'b0;
        4'd2: exp_ncs = 1'b1;
        4'd3: nstart = 1;
        4'd4: begin nstart = 1; exp_fifo.push_back(next_rx); end
        4'd5: begin nstart = 1; exp_fifo.push_back(next_rx); end
        4'd0, 4'd6: ;
        default: exp_err = 1'b1;
      endcase
      checks++;
      if (spi_ncs_o !== exp_ncs || err_o !== exp_err || start_cnt - s0 != nstart ||
          rd_valid_o !== (exp_fifo.size() != 0)) begin
        failures++;
        $display("FAIL rand_cmd_%0d op=%0d: ncs=%b err=%b starts=%0d rv=%b required %b %b %0d %b",
                 it, op, spi_ncs_o, err_o, start_cnt - s0, rd_valid_o, exp_ncs, exp_err, nstart, exp_fifo.size() != 0);
      end
      if (nstart == 1) begin
        checks++;
        if (tx_log.size() != 1 || tx_log[0] !== ((op == 4'd4) ? 8'h00 : arg)) begin
          failures++; $display("FAIL rand_tx_%0d: logged=%0d required one byte of %h", it, tx_log.size(), (op == 4'd4) ? 8'h00 : arg);
        end
      end
      tx_log.delete();
    end
    while (exp_fifo.size() != 0) begin
      checks++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== exp_fifo[0]) begin
        failures++; $display("FAIL rand_drain: rv=%b rd=%h required 1 %h", rd_valid_o, rd_data_o, exp_fifo[0]);
      end
      pop_head();
    end
  endtask

  function automatic logic rv_str();
    return rd_valid_o;
  endfunction

  task automatic test_reset_mid();
    int c, s0;
    slave_lat = 2;
    send_cmd(4'd1, 8'h00);
    next_rx = 8'h5A;
    send_cmd(4'd5, 8'h99);
    wait_ready(c);
    slave_en = 1'b0;
    send_cmd(4'd3, 8'h77);
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || rd_valid_o !== 1'b1 || spi_ncs_o !== 1'b0) begin
      failures++; $display("FAIL pre_reset: busy=%b rv=%b ncs=%b required 1 1 0", busy_o, rd_valid_o, spi_ncs_o);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready_o, xfer_start_o, xfer_tx_o, spi_ncs_o, rd_valid_o, rd_data_o, busy_o, err_o}
        !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_values: rdy=%b st=%b tx=%h ncs=%b rv=%b rd=%h busy=%b err=%b",
               cmd_ready_o, xfer_start_o, xfer_tx_o, spi_ncs_o, rd_valid_o, rd_data_o, busy_o, err_o);
    end
    exp_fifo.delete();
    exp_err = 1'b0;
    exp_ncs = 1'b1;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    s0 = start_cnt;
    tb_rx = 8'hEE;
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_valid_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || start_cnt != s0) begin
      failures++; $display("FAIL late_done: rv=%b busy=%b rdy=%b starts=%0d required 0 0 1 0", rd_valid_o, busy_o, cmd_ready_o, start_cnt - s0);
    end
    tx_log.delete();
    slave_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cs_write();
    test_xchg();
    test_fifo_stall();
    test_delay();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
